// File: rtl/min_sweep_if.sv
// Stimulus/capture bundle between min_sweep and its environment: start/status,
// the code driven to min.a, the returned min.d, and the table. Optional ones via MIN_SWEEP_ONES_EN.
interface min_sweep_if;
  logic        start;
  logic [3:0]  a;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
`ifdef MIN_SWEEP_ONES_EN
  logic [4:0]  ones;
`endif

  modport master (
    input  start,
    input  d,
    output a,
    output busy,
    output done,
`ifdef MIN_SWEEP_ONES_EN
    output ones,
`endif
    output table_out
  );

  modport slave (
    output start,
    output d,
    input  a,
    input  busy,
    input  done,
`ifdef MIN_SWEEP_ONES_EN
    input  ones,
`endif
    input  table_out
  );
endinterface

// File: rtl/min_sweep.sv
// Sweeps codes 0..15 onto min.a, holding each HOLD cycles, and captures min.d into a truth table.
// MIN_SWEEP_ONES_EN adds a registered population count of the captured table.
module min_sweep #(
  parameter int unsigned HOLD = 1
) (
  input logic        clk,
  input logic        rst,
  min_sweep_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [3:0]  r_a;
  logic [3:0]  r_cnt;
  logic [15:0] r_table;
  logic        w_hit;
  logic        w_busy;
  logic        w_done;
`ifdef MIN_SWEEP_ONES_EN
  logic [4:0]  r_ones;
`endif

  assign w_hit = (r_cnt == HOLD_M1);

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = SWEEP;
      end
      SWEEP: begin
        w_busy = 1'b1;
        if (w_hit && (r_idx == 4'hF)) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_cnt   <= '0;
      r_table <= '0;
`ifdef MIN_SWEEP_ONES_EN
      r_ones  <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_cnt   <= '0;
            r_table <= '0;
`ifdef MIN_SWEEP_ONES_EN
            r_ones  <= '0;
`endif
          end
        end
        SWEEP: begin
          if (w_hit) begin
            r_table[r_idx] <= bus.d;
            r_cnt          <= '0;
`ifdef MIN_SWEEP_ONES_EN
            r_ones         <= r_ones + 5'(bus.d);
`endif
            // Last code: park a at 0 as DONE is entered instead of wrapping the index.
            if (r_idx != 4'hF) begin
              r_idx <= r_idx + 4'd1;
              r_a   <= r_a + 4'd1;
            end else begin
              r_a   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          r_a <= '0;
        end
        default: begin
          r_a <= '0;
        end
      endcase
    end
  end

  assign bus.a         = r_a;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.table_out = r_table;
`ifdef MIN_SWEEP_ONES_EN
  assign bus.ones      = r_ones;
`endif

endmodule

// File: tb/tb_min_sweep.sv
// Bench for min_sweep: two instances (HOLD=1 and HOLD=3) driven by truth-table models of min,
// compared each cycle against an arithmetic model of the sweep timing.
module tb_min_sweep;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        r_start [2];
  logic [15:0] r_tt    [2];
  logic [3:0]  w_a     [2];
  logic        w_busy  [2];
  logic        w_done  [2];
  logic [15:0] w_tab   [2];
  logic [4:0]  w_ones  [2];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  min_sweep_if u_if1 ();
  min_sweep_if u_if3 ();

  min_sweep #(.HOLD(1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1.master));
  min_sweep #(.HOLD(3)) u_dut3 (.clk(clk), .rst(rst), .bus(u_if3.master));

  assign u_if1.start = r_start[0];
  assign u_if3.start = r_start[1];
  assign u_if1.d     = r_tt[0][u_if1.a];
  assign u_if3.d     = r_tt[1][u_if3.a];

  assign w_a[0]    = u_if1.a;
  assign w_a[1]    = u_if3.a;
  assign w_busy[0] = u_if1.busy;
  assign w_busy[1] = u_if3.busy;
  assign w_done[0] = u_if1.done;
  assign w_done[1] = u_if3.done;
  assign w_tab[0]  = u_if1.table_out;
  assign w_tab[1]  = u_if3.table_out;
`ifdef MIN_SWEEP_ONES_EN
  assign w_ones[0] = u_if1.ones;
  assign w_ones[1] = u_if3.ones;
`else
  assign w_ones[0] = '0;
  assign w_ones[1] = '0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_ones(input int unsigned u, input logic [15:0] tt);
`ifdef MIN_SWEEP_ONES_EN
    check("ones", 32'(w_ones[u]), 32'($countones(tt)));
`endif
  endtask

  // One sweep on unit u: model says a = c/hold after edge k+c, done after edge k+16*hold.
  task automatic run_sweep(input int unsigned u, input int unsigned hold,
                           input logic [15:0] tt, input bit poke, input bit kill);
    r_tt[u] = tt;
    @(negedge clk);
    r_start[u] = 1'b1;
    @(posedge clk);
    #1 r_start[u] = 1'b0;
    for (int unsigned c = 0; c < 16 * hold; c++) begin
      check("a_step", 32'(w_a[u]), c / hold);
      check("busy_sweep", 32'(w_busy[u]), 32'd1);
      check("done_sweep", 32'(w_done[u]), 32'd0);
      if (poke && c == 5) r_start[u] = 1'b1;
      if (poke && c == 6) r_start[u] = 1'b0;
      if (kill && c == 8) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("kill_a", 32'(w_a[u]), 32'd0);
        check("kill_busy", 32'(w_busy[u]), 32'd0);
        check("kill_done", 32'(w_done[u]), 32'd0);
        check("kill_table", 32'(w_tab[u]), 32'd0);
        check_ones(u, 16'h0000);
        return;
      end
      @(posedge clk);
      #1;
    end
    check("done_pulse", 32'(w_done[u]), 32'd1);
    check("done_busy", 32'(w_busy[u]), 32'd0);
    check("done_a", 32'(w_a[u]), 32'd0);
    check("table", 32'(w_tab[u]), 32'(tt));
    check_ones(u, tt);
    for (int unsigned j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      check("idle_done", 32'(w_done[u]), 32'd0);
      check("idle_busy", 32'(w_busy[u]), 32'd0);
      check("table_hold", 32'(w_tab[u]), 32'(tt));
    end
  endtask

  initial begin
    r_start[0] = 1'b0;
    r_start[1] = 1'b0;
    r_tt[0]    = '0;
    r_tt[1]    = '0;

    // Reset held 2 cycles with start asserted: nothing may launch.
    @(negedge clk);
    rst        = 1'b1;
    r_start[0] = 1'b1;
    r_start[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int unsigned u = 0; u < 2; u++) begin
      check("rst_a", 32'(w_a[u]), 32'd0);
      check("rst_busy", 32'(w_busy[u]), 32'd0);
      check("rst_done", 32'(w_done[u]), 32'd0);
      check("rst_table", 32'(w_tab[u]), 32'd0);
      check_ones(u, 16'h0000);
    end
    @(negedge clk);
    r_start[0] = 1'b0;
    r_start[1] = 1'b0;
    rst        = 1'b0;
    repeat (2) @(posedge clk);

    run_sweep(0, 1, 16'h9307, 1'b0, 1'b0);
    run_sweep(0, 1, 16'h9307, 1'b1, 1'b0);
    run_sweep(0, 1, 16'h9307, 1'b0, 1'b1);
    run_sweep(0, 1, 16'h9307, 1'b0, 1'b0);
    run_sweep(1, 3, 16'h9307, 1'b0, 1'b0);
    run_sweep(1, 3, 16'h9307, 1'b1, 1'b0);
    run_sweep(0, 1, 16'hFFFF, 1'b0, 1'b0);
    run_sweep(0, 1, 16'h0000, 1'b0, 1'b0);
    run_sweep(1, 3, 16'hFFFF, 1'b0, 1'b0);
    run_sweep(1, 3, 16'h0000, 1'b0, 1'b0);

    for (int unsigned n = 0; n < 6; n++) begin
      logic [15:0] tt;
      tt = 16'($urandom);
      run_sweep(n % 2, (n % 2 == 0) ? 1 : 3, tt, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/min_sweep.md
# min_sweep

Sequential stimulus-and-capture stage wrapped around the 4-input minimised-function block `min`. On `start` it drives every 4-bit code 0..15 onto `min`'s `a` input in ascending order and samples the returned `d` for each code. The 16 samples are assembled into a truth-table word so that the hardware result can be checked against the intended minterm set. It sits directly upstream of `min` (feeding `a`) and also consumes `d`.

## Interface
- `HOLD`, default 1: number of clock cycles each code is held on `a` before `d` is sampled. Legal range is 1..15.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request to begin a sweep. Sampled only in IDLE.
- `a` out 4: registered code driven to `min.a`.
- `d` in 1: combinational result from `min.d`.
- `busy` out 1: high while a sweep is in progress (SWEEP state).
- `done` out 1: one-cycle pulse when the table is complete.
- `table_out` out 16: bit i holds `d` as sampled for code i.
- `ones` out 5: population count of `table_out`. Present only with `MIN_SWEEP_ONES_EN`.

## Operation
- FSM states: IDLE, SWEEP, DONE. Reset state is IDLE.
- Reset values: `a`=0, `busy`=0, `done`=0, `table_out`=0, `ones`=0, internal index=0, hold counter=0.
- IDLE → SWEEP when `start`=1. On that edge:
  - `table_out` is cleared to 0.
  - index is set to 0 and `a` is set to 0.
  - hold counter is set to 0.
  - `busy` rises.
- In SWEEP, the hold counter increments on every cycle.
- When the hold counter reaches HOLD−1:
  - `d` is written into `table_out[index]` and the hold counter is cleared.
  - If index < 15: index and `a` increment.
  - If index = 15: go to DONE.
- In DONE: `a`=0, `busy`=0, `done`=1. Next edge returns unconditionally to IDLE.
- `start` is ignored in SWEEP and DONE. A held-high `start` relaunches a sweep from IDLE on the edge after DONE.
- `table_out` is held stable from DONE until the next accepted `start` or reset.
- `a` is only ever a registered value, so `min` sees glitch-free inputs. `d` is sampled at least one full cycle after `a` changes.
- Reset mid-sweep returns to IDLE with all reset values; partial table contents are discarded.
- Index arithmetic is 4-bit. There is no wrap past 15, because DONE is entered instead.

## Timing
- Let the accepted `start` be at edge k.
- `a` = i during edges k+HOLD·i+1 through k+HOLD·(i+1). Sample i is taken at edge k+HOLD·(i+1).
- DONE is entered at edge k+16·HOLD. `done`=1 for exactly the following cycle.
- IDLE is re-entered at edge k+16·HOLD+1.
- With HOLD=1: `busy` is high for 16 cycles, and `done` is seen in the 17th cycle after `start` was sampled.
- `ones` is registered and updates on the same edge as `table_out`, so it is valid when `done`=1.

## Configuration
- `MIN_SWEEP_ONES_EN` defined:
  - `ones` port exists.
  - A 5-bit counter increments on each sampled `d`=1.
  - It clears on an accepted `start` and on reset. Range is 0..16.
- Undefined: the `ones` port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: assert `rst` for 2 cycles with `start`=1 → `a`=0, `busy`=0, `done`=0, `table_out`=0x0000; no sweep starts during reset.
- Full sweep with real `min`, HOLD=1:
  - pulse `start` → `a` steps 0..15 on consecutive cycles.
  - `done` pulses 17 cycles after start; `table_out`=0x9307 (minterms 0,1,2,8,9,12,15).
  - `ones`=7 (with macro).
- Start while busy: re-pulse `start` at sweep cycle 5 → no restart; `done` timing unchanged; `table_out`=0x9307.
- Reset mid-sweep: assert `rst` at sweep cycle 8 → next cycle `a`=0, `busy`=0, `table_out`=0; a fresh `start` then yields 0x9307.
- HOLD=3: each `a` value persists 3 cycles; `done` arrives 49 cycles after start; `table_out`=0x9307.
- `d` forced to 1 → `table_out`=0xFFFF, `ones`=16. `d` forced to 0 → `table_out`=0x0000, `ones`=0.
